// File: rtl/knight_pkg.sv
// Shared opcodes, heading constants, FSM state type and small helpers
// for the Knight command executor.
package knight_pkg;

    localparam logic [3:0] CAL      = 4'b0000;
    localparam logic [3:0] MOVE     = 4'b0010;
    localparam logic [3:0] MOVE_FAN = 4'b0011;
    localparam logic [3:0] TOUR     = 4'b0100;

    localparam logic [7:0] NORTH = 8'h00;
    localparam logic [7:0] WEST  = 8'h3F;
    localparam logic [7:0] SOUTH = 8'h7F;
    localparam logic [7:0] EAST  = 8'hBF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAL,
        S_HEAD,
        S_RAMP_UP,
        S_RAMP_DN
    } state_t;

    // Magnitude of a 12-bit two's-complement value; the most negative code
    // has no positive counterpart, so it clips to the largest positive one.
    function automatic logic [11:0] abs_sat(input logic [11:0] v);
        if (v == 12'h800)
            return 12'h7FF;
        else if (v[11])
            return (~v) + 12'd1;
        else
            return v;
    endfunction

    // North is the only heading that is not padded with 4'hF in the low bits.
    function automatic logic [11:0] heading_target(input logic [7:0] h);
        if (h == NORTH)
            return 12'h000;
        else
            return {h, 4'hF};
    endfunction

endpackage

// File: rtl/knight_cmd_exec_fwd_ramp.sv
// Forward-speed register: saturating ramp up by one step, ramp down by two
// steps with a floor at zero, or synchronous clear.
module fwd_ramp #(
    parameter logic [10:0] FRWRD_STEP = 11'd16,
    parameter logic [10:0] MAX_FRWRD  = 11'h2A0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc,
    input  logic        i_dec,
    input  logic        i_clr,
    output logic [10:0] o_frwrd
);

    logic [10:0] r_frwrd;
    logic [11:0] w_sum;
    logic [11:0] w_dn_step;

    assign w_sum     = {1'b0, r_frwrd} + {1'b0, FRWRD_STEP};
    assign w_dn_step = {FRWRD_STEP, 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frwrd <= 11'd0;
        end else if (i_clr) begin
            r_frwrd <= 11'd0;
        end else if (i_inc) begin
            r_frwrd <= (w_sum > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : w_sum[10:0];
        end else if (i_dec) begin
            r_frwrd <= ({1'b0, r_frwrd} <= w_dn_step) ? 11'd0 : (r_frwrd - w_dn_step[10:0]);
        end
    end

    assign o_frwrd = r_frwrd;

endmodule

// File: rtl/knight_cmd_exec.sv
// Knight command responder: acknowledges commands from the command mux and
// runs calibrate, heading-then-forward move (optional fanfare) or tour start.
module knight_cmd_exec
    import knight_pkg::*;
#(
    parameter logic [11:0] HEAD_TOL   = 12'h02C,
    parameter logic [10:0] FRWRD_STEP = 11'd16,
    parameter logic [10:0] MAX_FRWRD  = 11'h2A0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    output logic        send_resp,
    output logic        strt_cal,
    input  logic        cal_done,
    output logic        tour_go,
    output logic [11:0] desired_heading,
    input  logic [11:0] error,
    output logic        moving,
    output logic [10:0] frwrd,
    input  logic        cntrIR,
    output logic        fanfare_go
);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_opcode;
    logic [3:0]  r_squares;
    logic [4:0]  r_line_cnt;
    logic        r_cntrIR_q;
    logic [11:0] r_desired_heading;
    logic        r_send_resp;
    logic        r_fanfare_go;

    logic        w_accept;
    logic        w_cntr_rise;
    logic        w_target_hit;
    logic        w_head_ok;
    logic        w_strt;
    logic        w_tour;
    logic        w_load_move;
    logic        w_inc;
    logic        w_dec;
    logic        w_clr;
    logic        w_count;
    logic        w_send_next;
    logic        w_fan_next;
    logic [10:0] w_frwrd;

    // Each square crossing produces two rising edges, hence the doubled target.
    assign w_accept     = (r_state == S_IDLE) && cmd_rdy && !rst;
    assign w_cntr_rise  = cntrIR & ~r_cntrIR_q;
    assign w_target_hit = (r_line_cnt == {r_squares, 1'b0});
    assign w_head_ok    = (abs_sat(error) < HEAD_TOL);

    always_comb begin
        w_state_next = r_state;
        w_strt       = 1'b0;
        w_tour       = 1'b0;
        w_load_move  = 1'b0;
        w_inc        = 1'b0;
        w_dec        = 1'b0;
        w_clr        = 1'b0;
        w_count      = 1'b0;
        w_send_next  = 1'b0;
        w_fan_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (cmd[15:12])
                        CAL: begin
                            w_strt       = 1'b1;
                            w_state_next = S_CAL;
                        end
                        MOVE, MOVE_FAN: begin
                            w_load_move  = 1'b1;
                            w_state_next = S_HEAD;
                        end
                        TOUR:    w_tour = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_CAL: begin
                if (cal_done) begin
                    w_send_next  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_HEAD: begin
                w_clr = 1'b1;
                if (w_head_ok)
                    w_state_next = S_RAMP_UP;
            end
            S_RAMP_UP: begin
                // Target check wins over a coincident sensor edge.
                if (w_target_hit) begin
                    w_state_next = S_RAMP_DN;
                end else begin
                    w_inc   = 1'b1;
                    w_count = w_cntr_rise;
                end
            end
            S_RAMP_DN: begin
                if (w_frwrd == 11'd0) begin
                    w_send_next  = 1'b1;
                    w_fan_next   = (r_opcode == MOVE_FAN);
                    w_state_next = S_IDLE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= S_IDLE;
            r_opcode          <= 4'd0;
            r_squares         <= 4'd0;
            r_line_cnt        <= 5'd0;
            r_cntrIR_q        <= 1'b0;
            r_desired_heading <= 12'h000;
            r_send_resp       <= 1'b0;
            r_fanfare_go      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cntrIR_q   <= cntrIR;
            r_send_resp  <= w_send_next;
            r_fanfare_go <= w_fan_next;
            if (w_accept) begin
                r_opcode  <= cmd[15:12];
                r_squares <= cmd[3:0];
            end
            if (w_load_move) begin
                r_line_cnt        <= 5'd0;
                r_desired_heading <= heading_target(cmd[11:4]);
            end else if (w_count) begin
                r_line_cnt <= r_line_cnt + 5'd1;
            end
        end
    end

    fwd_ramp #(
        .FRWRD_STEP(FRWRD_STEP),
        .MAX_FRWRD (MAX_FRWRD)
    ) u_ramp (
        .clk    (clk),
        .rst    (rst),
        .i_inc  (w_inc),
        .i_dec  (w_dec),
        .i_clr  (w_clr),
        .o_frwrd(w_frwrd)
    );

    assign clr_cmd_rdy     = w_accept;
    assign strt_cal        = w_strt;
    assign tour_go         = w_tour;
    assign send_resp       = r_send_resp;
    assign fanfare_go      = r_fanfare_go;
    assign desired_heading = r_desired_heading;
    assign frwrd           = w_frwrd;
    assign moving          = (r_state == S_HEAD) || (r_state == S_RAMP_UP) || (r_state == S_RAMP_DN);

endmodule

// File: tb/tb_knight_cmd_exec.sv
// Self-checking bench for knight_cmd_exec: table-driven commands, hand-written
// busy/reset sequences and random commands, all against a behavioural model.
module tb_knight_cmd_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic        strt_cal;
    logic        cal_done;
    logic        tour_go;
    logic [11:0] desired_heading;
    logic [11:0] error;
    logic        moving;
    logic [10:0] frwrd;
    logic        cntrIR;
    logic        fanfare_go;

    always #5 clk = ~clk;

    knight_cmd_exec dut (
        .clk            (clk),
        .rst            (rst),
        .cmd            (cmd),
        .cmd_rdy        (cmd_rdy),
        .clr_cmd_rdy    (clr_cmd_rdy),
        .send_resp      (send_resp),
        .strt_cal       (strt_cal),
        .cal_done       (cal_done),
        .tour_go        (tour_go),
        .desired_heading(desired_heading),
        .error          (error),
        .moving         (moving),
        .frwrd          (frwrd),
        .cntrIR         (cntrIR),
        .fanfare_go     (fanfare_go)
    );

    // Behavioural reference: phase of the command, speed as a plain integer,
    // crossings seen, and the pulses due in the current cycle.
    localparam int P_IDLE = 0, P_CAL = 1, P_HEAD = 2, P_UP = 3, P_DN = 4;
    localparam int TOL = 44, STEP = 16, TOP = 672;

    int          m_phase, m_speed, m_cross, m_target, m_op;
    logic [11:0] m_dh;
    bit          m_send, m_fan, m_prev, m_acc_evt;

    int n_checks = 0;
    int n_errs   = 0;
    int c_clr, c_strt, c_tour, c_send, c_fan, peak;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_speed = 0; m_cross = 0; m_target = 0; m_op = 0;
        m_dh = 12'h000; m_send = 0; m_fan = 0; m_prev = 0; m_acc_evt = 0;
    endtask

    task automatic model_edge();
        int  mag;
        bit  rise;
        bit  nsend, nfan;
        if (rst) begin
            model_reset();
            return;
        end
        m_acc_evt = 0; nsend = 0; nfan = 0;
        rise = cntrIR && !m_prev;
        case (m_phase)
            P_IDLE: if (cmd_rdy) begin
                m_acc_evt = 1;
                m_op = int'(cmd[15:12]);
                if (m_op == 0) begin
                    m_phase = P_CAL;
                end else if (m_op == 2 || m_op == 3) begin
                    m_target = 2 * int'(cmd[3:0]);
                    m_cross  = 0;
                    m_dh     = (cmd[11:4] == 8'h00) ? 12'h000 : {cmd[11:4], 4'hF};
                    m_phase  = P_HEAD;
                end
            end
            P_CAL: if (cal_done) begin
                m_phase = P_IDLE;
                nsend = 1;
            end
            P_HEAD: begin
                m_speed = 0;
                mag = $signed(error);
                if (mag < 0) mag = -mag;
                if (mag > 2047) mag = 2047;
                if (mag < TOL) m_phase = P_UP;
            end
            P_UP: begin
                if (m_cross == m_target) begin
                    m_phase = P_DN;
                end else begin
                    m_speed = (m_speed + STEP > TOP) ? TOP : m_speed + STEP;
                    if (rise) m_cross++;
                end
            end
            P_DN: begin
                if (m_speed == 0) begin
                    m_phase = P_IDLE;
                    nsend = 1;
                    nfan = (m_op == 3);
                end else begin
                    m_speed = (m_speed > 2 * STEP) ? m_speed - 2 * STEP : 0;
                end
            end
            default: m_phase = P_IDLE;
        endcase
        m_send = nsend;
        m_fan  = nfan;
        m_prev = cntrIR;
    endtask

    task automatic check_mealy();
        int exp_clr;
        exp_clr = (!rst && m_phase == P_IDLE && cmd_rdy) ? 1 : 0;
        chk("clr_cmd_rdy", int'(clr_cmd_rdy), exp_clr);
        chk("strt_cal", int'(strt_cal), (exp_clr == 1 && cmd[15:12] == 4'h0) ? 1 : 0);
        chk("tour_go", int'(tour_go), (exp_clr == 1 && cmd[15:12] == 4'h4) ? 1 : 0);
        c_clr  += int'(clr_cmd_rdy);
        c_strt += int'(strt_cal);
        c_tour += int'(tour_go);
    endtask

    task automatic check_regs();
        chk("frwrd", int'(frwrd), m_speed);
        chk("moving", int'(moving), (m_phase >= P_HEAD) ? 1 : 0);
        chk("send_resp", int'(send_resp), int'(m_send));
        chk("fanfare_go", int'(fanfare_go), int'(m_fan));
        chk("desired_heading", int'(desired_heading), int'(m_dh));
        c_send += int'(send_resp);
        c_fan  += int'(fanfare_go);
        if (int'(frwrd) > peak) peak = int'(frwrd);
    endtask

    task automatic tick();
        @(negedge clk);
        check_mealy();
        @(posedge clk);
        model_edge();
        #1;
        check_regs();
    endtask

    task automatic clear_counts();
        c_clr = 0; c_strt = 0; c_tour = 0; c_send = 0; c_fan = 0; peak = 0;
    endtask

    // Issue one command and play the environment until it has been retired.
    task automatic run_cmd(input logic [15:0] c, input int settle, input logic [11:0] pre_err,
                           input logic [11:0] post_err, input int half, input int cal_dly);
        int  budget, since, edges_made, pc, want;
        bit  accepted, nv, is_move;
        clear_counts();
        cmd = c; cmd_rdy = 1'b1; error = pre_err;
        accepted = 0; since = 0; edges_made = 0; pc = 0;
        is_move = (c[15:12] == 4'h2 || c[15:12] == 4'h3);
        want = is_move ? 2 * int'(c[3:0]) : 0;
        for (budget = 0; budget < 3000; budget++) begin
            tick();
            if (!accepted && m_acc_evt) begin
                accepted = 1; cmd_rdy = 1'b0; since = 0;
            end else if (accepted) begin
                since++;
            end
            if (accepted) begin
                cal_done = (c[15:12] == 4'h0 && since == cal_dly);
                if (since >= settle) error = post_err;
                if (since >= settle + 3 && edges_made < want) begin
                    pc++;
                    nv = ((pc / half) % 2) == 1;
                    if (nv && !cntrIR) edges_made++;
                    cntrIR = nv;
                end else begin
                    cntrIR = 1'b0;
                end
                if (m_phase == P_IDLE && since >= 2) break;
            end
        end
        cal_done = 1'b0; cntrIR = 1'b0;
        if (budget >= 3000) begin
            n_checks++; n_errs++;
            $display("FAIL run_cmd_timeout: cmd %h never retired (t=%0t)", c, $time);
        end
    endtask

    typedef struct {
        logic [15:0] c;
        int          settle;
        logic [11:0] pre;
        logic [11:0] post;
        int          half;
        int          cal;
        int          exp_dh;
        int          exp_resp;
        int          exp_fan;
        int          exp_tour;
        int          exp_strt;
        int          exp_peak;
    } vec_t;

    vec_t tbl [8];

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          budget;
        logic [15:0] rc;
        logic [3:0]  op;
        logic [11:0] pre, post;
        int          v;

        tbl[0] = '{16'h0000, 0,  12'h100, 12'h010, 8, 20, -1,     1, 0, 0, 1, 0};
        tbl[1] = '{16'h2002, 10, 12'h100, 12'h010, 8, 0,  12'h000, 1, 0, 0, 0, 12'h2A0};
        tbl[2] = '{16'h3BF1, 2,  12'h100, 12'h010, 8, 0,  12'hBFF, 1, 1, 0, 0, -1};
        tbl[3] = '{16'h4000, 0,  12'h100, 12'h010, 8, 0,  -1,     0, 0, 1, 0, 0};
        tbl[4] = '{16'h7123, 0,  12'h100, 12'h010, 8, 0,  -1,     0, 0, 0, 0, 0};
        tbl[5] = '{16'h2000, 3,  12'h100, 12'h010, 8, 0,  12'h000, 1, 0, 0, 0, 0};
        tbl[6] = '{16'h27F3, 4,  12'h02C, 12'hFD5, 8, 0,  12'h7FF, 1, 0, 0, 0, 12'h2A0};
        tbl[7] = '{16'h33F1, 5,  12'h800, 12'h02B, 8, 0,  12'h3FF, 1, 1, 0, 0, -1};

        rst = 1'b1; cmd = 16'h0000; cmd_rdy = 1'b0; cal_done = 1'b0;
        error = 12'h000; cntrIR = 1'b0;
        model_reset();
        clear_counts();
        #1;
        check_regs();
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_cmd(tbl[i].c, tbl[i].settle, tbl[i].pre, tbl[i].post, tbl[i].half, tbl[i].cal);
            chk("tbl_clr_count", c_clr, 1);
            chk("tbl_send_count", c_send, tbl[i].exp_resp);
            chk("tbl_fan_count", c_fan, tbl[i].exp_fan);
            chk("tbl_tour_count", c_tour, tbl[i].exp_tour);
            chk("tbl_strt_count", c_strt, tbl[i].exp_strt);
            if (tbl[i].exp_dh >= 0) chk("tbl_desired_heading", int'(desired_heading), tbl[i].exp_dh);
            if (tbl[i].exp_peak >= 0) chk("tbl_peak_frwrd", peak, tbl[i].exp_peak);
            $display("table %0d cmd=%h resp=%0d fan=%0d tour=%0d peak=%0h", i, tbl[i].c, c_send, c_fan, c_tour, peak);
        end

        // Busy: a command offered during a move waits until IDLE.
        clear_counts();
        cmd = 16'h2001; cmd_rdy = 1'b1; error = 12'h000;
        tick();
        cmd_rdy = 1'b0;
        repeat (3) tick();
        cmd = 16'h7000; cmd_rdy = 1'b1;
        repeat (6) tick();
        chk("busy_no_ack", c_clr, 1);
        repeat (2) begin
            cntrIR = 1'b1; repeat (3) tick();
            cntrIR = 1'b0; repeat (3) tick();
        end
        for (budget = 0; budget < 200 && !m_acc_evt; budget++) tick();
        cmd_rdy = 1'b0;
        if (budget >= 200) begin
            n_checks++; n_errs++;
            $display("FAIL busy_timeout: queued command never acknowledged");
        end
        repeat (3) tick();
        chk("busy_clr_total", c_clr, 2);
        chk("busy_send_total", c_send, 1);
        chk("busy_illegal_no_tour", c_tour, 0);
        $display("busy move+illegal clr=%0d resp=%0d", c_clr, c_send);

        // Reset in the middle of a ramp-up.
        clear_counts();
        cmd = 16'h2003; cmd_rdy = 1'b1; error = 12'h000;
        tick();
        cmd_rdy = 1'b0;
        for (budget = 0; budget < 100 && m_speed != 128; budget++) tick();
        if (budget >= 100) begin
            n_checks++; n_errs++;
            $display("FAIL rst_setup: frwrd never reached 0x80");
        end
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_async_frwrd", int'(frwrd), 0);
        chk("rst_async_moving", int'(moving), 0);
        tick();
        rst = 1'b0;
        tick();
        $display("reset mid-ramp frwrd=%0h moving=%0d", frwrd, moving);
        run_cmd(16'h2000, 1, 12'h100, 12'h000, 4, 0);
        chk("zero_sq_peak", peak, 0);
        chk("zero_sq_send", c_send, 1);
        $display("zero squares resp=%0d peak=%0h", c_send, peak);

        for (int t = 0; t < 30; t++) begin
            case ($urandom_range(0, 5))
                0:       op = 4'h0;
                1, 5:    op = 4'h2;
                2:       op = 4'h3;
                3:       op = 4'h4;
                default: op = 4'($urandom_range(5, 15));
            endcase
            rc = {op, 8'($urandom_range(0, 255)), 4'($urandom_range(0, 2))};
            case ($urandom_range(0, 3))
                0:       pre = 12'h02C;
                1:       pre = 12'hFD4;
                2:       pre = 12'h800;
                default: pre = 12'($urandom_range(0, 4095));
            endcase
            v = int'($urandom_range(0, 86)) - 43;
            post = v[11:0];
            run_cmd(rc, int'($urandom_range(0, 8)), pre, post,
                    int'($urandom_range(2, 6)), int'($urandom_range(0, 10)));
            chk("rand_clr_count", c_clr, 1);
            $display("rand %0d cmd=%h resp=%0d fan=%0d tour=%0d peak=%0h", t, rc, c_send, c_fan, c_tour, peak);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
